// File: rtl/fxp_pkg.sv
// Shared fixed-point package: word format and the divider FSM encoding.
// Also used by the Q12 multiplier and the adder.
package fxp_pkg;

    localparam int FXP_N = 16;                // total width, sign included
    localparam int FXP_Q = 12;                // fraction bits
    localparam int FXP_W = FXP_N - 1 + FXP_Q; // divider working width / iterations

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fxp_state_e;

endpackage

// File: rtl/fxp_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// remainder and subtract the divisor when it fits.
module fxp_div_step #(
    parameter int N = 16
) (
    input  logic [N-1:0] rem,
    input  logic         d_msb,
    input  logic [N-2:0] divisor,
    output logic [N-1:0] rem_next,
    output logic         q_bit
);

    logic [N:0]   trial;
    logic [N-1:0] diff;

    // trial remainder, compare and conditional restore
    always_comb begin
        trial    = {rem, d_msb};
        diff     = trial[N-1:0] - {1'b0, divisor};
        q_bit    = (trial >= {2'b00, divisor});
        rem_next = q_bit ? diff : trial[N-1:0];
    end

endmodule

// File: rtl/fixed_point_divider_16b.sv
// Sequential sign-magnitude Q-format divider, one quotient bit per clock.
// FSM IDLE/RUN/DONE; result registers change only on completion or reset.
module fixed_point_divider_16b
    import fxp_pkg::*;
#(
    parameter int Q = FXP_Q,
    parameter int N = FXP_N
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    output logic [N-1:0] o_quotient,
    output logic         o_complete,
    output logic         o_busy,
    output logic         o_ovr,
    output logic         o_div_by_zero
);

    localparam int W  = N - 1 + Q;
    localparam int CW = $clog2(W + 1);

    fxp_state_e    state_r, state_nxt;
    logic [CW-1:0] cnt_r;
    logic          sign_r;
    logic [N-2:0]  dvsr_r;
    logic [N-1:0]  rem_r;
    logic [W-1:0]  d_r;
    logic [W-2:0]  quot_r;   // top bit never needs storing: it arrives on the last step

    logic          accept;
    logic          dvsr_zero;
    logic          last_step;
    logic [N-1:0]  rem_nxt;
    logic          q_bit;
    logic [W-1:0]  quot_nxt;

    assign dvsr_zero = ~|i_divisor[N-2:0];
    assign accept    = i_start && (state_r == IDLE || state_r == DONE);
    assign last_step = (state_r == RUN) && (cnt_r == CW'(1));
    assign quot_nxt  = {quot_r, q_bit};

    fxp_div_step #(.N(N)) u_step (
        .rem      (rem_r),
        .d_msb    (d_r[W-1]),
        .divisor  (dvsr_r),
        .rem_next (rem_nxt),
        .q_bit    (q_bit)
    );

    // state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_r <= IDLE;
        else       state_r <= state_nxt;
    end

    // next-state: divide-by-zero skips RUN; DONE may chain straight into a new op
    always_comb begin
        state_nxt = state_r;
        unique case (state_r)
            IDLE:    if (i_start) state_nxt = dvsr_zero ? DONE : RUN;
            RUN:     if (cnt_r == CW'(1)) state_nxt = DONE;
            DONE:    state_nxt = i_start ? (dvsr_zero ? DONE : RUN) : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // status outputs decoded from state
    always_comb begin
        o_busy     = (state_r == RUN);
        o_complete = (state_r == DONE);
    end

    // datapath: operand capture, iteration, and result registration
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_r         <= '0;
            sign_r        <= 1'b0;
            dvsr_r        <= '0;
            rem_r         <= '0;
            d_r           <= '0;
            quot_r        <= '0;
            o_quotient    <= '0;
            o_ovr         <= 1'b0;
            o_div_by_zero <= 1'b0;
        end else if (accept) begin
            sign_r <= i_dividend[N-1] ^ i_divisor[N-1];
            dvsr_r <= i_divisor[N-2:0];
            d_r    <= {i_dividend[N-2:0], {Q{1'b0}}};
            rem_r  <= '0;
            quot_r <= '0;
            cnt_r  <= CW'(W);
            if (dvsr_zero) begin
                o_quotient    <= {i_dividend[N-1] ^ i_divisor[N-1], {(N-1){1'b1}}};
                o_ovr         <= 1'b1;
                o_div_by_zero <= 1'b1;
            end
        end else if (state_r == RUN) begin
            rem_r  <= rem_nxt;
            d_r    <= {d_r[W-2:0], 1'b0};
            quot_r <= quot_nxt[W-2:0];
            cnt_r  <= cnt_r - 1'b1;
            if (last_step) begin
                // overflow truncates to the low magnitude bits
                o_quotient    <= {sign_r, quot_nxt[N-2:0]};
                o_ovr         <= |quot_nxt[W-1:N-1];
                o_div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fixed_point_divider_16b.sv
// Randomised + directed bench for fixed_point_divider_16b against an
// arithmetic reference model (integer divide of the scaled magnitudes).
module tb_fixed_point_divider_16b;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_start = 1'b0;
    logic [15:0] i_dividend = '0;
    logic [15:0] i_divisor = '0;
    logic [15:0] o_quotient;
    logic        o_complete;
    logic        o_busy;
    logic        o_ovr;
    logic        o_div_by_zero;

    int n_chk = 0;
    int n_err = 0;
    logic [17:0] exp_prev = '0;   // {ovr, dbz, quotient} of the last completed op

    fixed_point_divider_16b dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_dividend    (i_dividend),
        .i_divisor     (i_divisor),
        .o_quotient    (o_quotient),
        .o_complete    (o_complete),
        .o_busy        (o_busy),
        .o_ovr         (o_ovr),
        .o_div_by_zero (o_div_by_zero)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {ovr, dbz, sign, magnitude}: true quotient of (|a| * 2^12) / |b|, low 15 bits kept
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b);
        logic        s;
        int unsigned num, den, qq;
        logic [31:0] qv;
        s   = a[15] ^ b[15];
        num = int'(a[14:0]) * 4096;
        den = int'(b[14:0]);
        if (den == 0) return {1'b1, 1'b1, s, 15'h7FFF};
        qq = num / den;
        qv = qq;
        return {(qq >= 32768), 1'b0, s, qv[14:0]};
    endfunction

    // one complete divide; optional stray start at cycle inj_edge, reset at cycle rst_edge
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input int inj_edge, input int rst_edge);
        logic [17:0] e;
        int          edges;
        int          busy_n;
        bit          dz;
        e  = model(a, b);
        dz = (b[14:0] == 15'd0);
        @(negedge i_clk);
        i_start = 1'b1; i_dividend = a; i_divisor = b;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        edges = 0; busy_n = 0;
        if (!dz) chk("held", {14'd0, o_ovr, o_div_by_zero, o_quotient}, {14'd0, exp_prev});
        while (!o_complete && edges < 40) begin
            if (o_busy) busy_n++;
            if (edges == rst_edge) begin
                #2 i_rst = 1'b1;
                #1;
                chk("rst_out", {12'd0, o_busy, o_complete, o_ovr, o_div_by_zero, o_quotient}, 32'd0);
                exp_prev = '0;
                return;
            end
            i_start = (edges == inj_edge);
            if (edges == inj_edge) begin
                i_dividend = 16'($urandom);
                i_divisor  = 16'($urandom_range(1, 32767));
            end
            @(posedge i_clk); #1;
            edges++;
        end
        i_start = 1'b0;
        chk("latency", edges, dz ? 0 : 27);
        chk("busy_cycles", busy_n, dz ? 0 : 27);
        chk("busy_at_done", {31'd0, o_busy}, 32'd0);
        chk("result", {14'd0, o_ovr, o_div_by_zero, o_quotient}, {14'd0, e});
        exp_prev = e;
    endtask

    initial begin
        int nc;
        #1 i_rst = 1'b1;
        #2;
        chk("reset_out", {12'd0, o_busy, o_complete, o_ovr, o_div_by_zero, o_quotient}, 32'd0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk) i_rst = 1'b0;

        // directed vectors, issued back-to-back from the DONE cycle
        run_op(16'h3000, 16'h2000, -1, -1);
        chk("v_3_2", {15'd0, o_ovr, o_quotient}, {15'd0, 1'b0, 16'h1800});
        run_op(16'h9800, 16'h0800, -1, -1);
        chk("v_neg", {15'd0, o_ovr, o_quotient}, {15'd0, 1'b0, 16'hB000});
        run_op(16'h1000, 16'h9000, -1, -1);
        chk("v_negdiv", {15'd0, o_ovr, o_quotient}, {15'd0, 1'b0, 16'h9000});
        run_op(16'h7000, 16'h0010, -1, -1);
        chk("v_ovr", {15'd0, o_ovr, o_quotient}, {15'd0, 1'b1, 16'h0000});
        run_op(16'h1000, 16'h3000, -1, -1);
        chk("v_third", {15'd0, o_ovr, o_quotient}, {15'd0, 1'b0, 16'h0555});
        run_op(16'h1000, 16'h8000, -1, -1);
        chk("v_dbz", {14'd0, o_ovr, o_div_by_zero, o_quotient}, {14'd0, 1'b1, 1'b1, 16'hFFFF});
        run_op(16'h8000, 16'h1000, -1, -1);
        chk("v_negzero", {15'd0, o_ovr, o_quotient}, {15'd0, 1'b0, 16'h8000});

        // stray start mid-divide must be ignored
        run_op(16'h2400, 16'h0C00, 10, -1);
        chk("v_ignore", {15'd0, o_ovr, o_quotient}, {15'd0, 1'b0, 16'h3000});

        // reset mid-divide, then no completion and a clean restart
        run_op(16'h5000, 16'h1000, -1, 15);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk) i_rst = 1'b0;
        nc = 0;
        repeat (32) begin
            @(posedge i_clk); #1;
            if (o_complete) nc++;
        end
        chk("no_complete_after_rst", nc, 0);
        run_op(16'h3000, 16'h2000, -1, -1);
        chk("v_after_rst", {15'd0, o_ovr, o_quotient}, {15'd0, 1'b0, 16'h1800});

        // random operands, mixed idle gaps and divisor classes
        for (int i = 0; i < 60; i++) begin
            logic [15:0] a, b;
            int mode;
            a    = 16'($urandom);
            mode = $urandom_range(0, 7);
            if (mode == 0)      b = {1'($urandom), 15'd0};
            else if (mode < 4)  b = {1'($urandom), 15'($urandom_range(4096, 32767))};
            else                b = 16'($urandom);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(posedge i_clk);
            run_op(a, b, -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
